// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request channel plus result channel with flags.
interface alu_seq_if #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          control;
    logic [WIDTH-1:0]    dataInACC;
    logic [WIDTH-1:0]    dataIn;
    logic [PC_WIDTH-1:0] pc;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    dataOut;
    logic                carry;
    logic                zero;
    logic                illegal;

    modport master (
        output in_valid, control, dataInACC, dataIn, pc, out_ready,
        input  in_ready, out_valid, dataOut, carry, zero, illegal
    );

    modport slave (
        input  in_valid, control, dataInACC, dataIn, pc, out_ready,
        output in_ready, out_valid, dataOut, carry, zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked accumulator ALU: single-cycle ADD/NAND/BNZ/SLT/SUB, bit-serial shifts,
// optional shift-add multiply enabled by the ALU_MUL_EN macro (otherwise opcode 111 is illegal).
module alu_seq #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input logic    clk,
    input logic    rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_BNZ  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic [1:0]          state;
    logic [2:0]          op;
    logic [WIDTH-1:0]    work;
    logic [CW-1:0]       cnt;

    logic [WIDTH-1:0]    a, b;
    logic [SW-1:0]       shamt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [WIDTH:0]      sum_ab, diff_ab;
    logic [WIDTH-1:0]    imm_res;
    logic                imm_carry, imm_illegal, go_busy;
    logic [WIDTH-1:0]    step_work;
    logic                step_bit;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]    mcand, mul_hi, step_hi;
    logic [WIDTH:0]      mul_sum;
`endif

    assign a     = bus.dataInACC;
    assign b     = bus.dataIn;
    assign shamt = b[SW-1:0];

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        imm_res     = '0;
        imm_carry   = 1'b0;
        imm_illegal = 1'b0;
        pc_inc      = bus.pc + PC_WIDTH'(1);
        sum_ab      = {1'b0, a} + {1'b0, b};
        diff_ab     = {1'b0, a} - {1'b0, b};
        case (bus.control)
            OP_ADD:  {imm_carry, imm_res} = sum_ab;
            OP_NAND: imm_res = ~(a & b);
            OP_BNZ: begin
                if (a != '0) imm_res[PC_WIDTH-1:0] = pc_inc;
                else         imm_res = b;
            end
            OP_SLT:  imm_res[0] = (a < b);
            OP_SUB:  {imm_carry, imm_res} = diff_ab;
            OP_SHL, OP_SHR: imm_res = a;
`ifdef ALU_MUL_EN
            default: ;
`else
            default: imm_illegal = 1'b1;
`endif
        endcase
    end

    always_comb begin
        go_busy = 1'b0;
        if ((bus.control == OP_SHL || bus.control == OP_SHR) && shamt != '0) go_busy = 1'b1;
`ifdef ALU_MUL_EN
        if (bus.control == OP_MUL) go_busy = 1'b1;
`endif
    end

    // One iteration of whichever multi-cycle op is in flight.
    always_comb begin
        step_work = work;
        step_bit  = 1'b0;
`ifdef ALU_MUL_EN
        step_hi   = mul_hi;
        mul_sum   = {1'b0, mul_hi} + (work[0] ? {1'b0, mcand} : '0);
`endif
        case (op)
            OP_SHL: {step_bit, step_work} = {work, 1'b0};
            OP_SHR: {step_work, step_bit} = {1'b0, work};
`ifdef ALU_MUL_EN
            OP_MUL: begin
                step_hi   = mul_sum[WIDTH:1];
                step_work = {mul_sum[0], work[WIDTH-1:1]};
                step_bit  = (step_hi != '0);
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= '0;
            work        <= '0;
            cnt         <= '0;
            bus.dataOut <= '0;
            bus.carry   <= 1'b0;
            bus.zero    <= 1'b0;
            bus.illegal <= 1'b0;
`ifdef ALU_MUL_EN
            mcand       <= '0;
            mul_hi      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op          <= bus.control;
                        bus.illegal <= imm_illegal;
                        if (go_busy) begin
                            state <= BUSY;
`ifdef ALU_MUL_EN
                            if (bus.control == OP_MUL) begin
                                work   <= b;
                                mcand  <= a;
                                mul_hi <= '0;
                                cnt    <= CW'(WIDTH);
                            end else begin
                                work <= a;
                                cnt  <= CW'(shamt);
                            end
`else
                            work <= a;
                            cnt  <= CW'(shamt);
`endif
                        end else begin
                            state       <= DONE;
                            bus.dataOut <= imm_res;
                            bus.carry   <= imm_carry;
                            bus.zero    <= (imm_res == '0);
                        end
                    end
                end
                BUSY: begin
                    work <= step_work;
                    cnt  <= cnt - CW'(1);
`ifdef ALU_MUL_EN
                    mul_hi <= step_hi;
`endif
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        bus.dataOut <= step_work;
                        bus.carry   <= step_bit;
                        bus.zero    <= (step_work == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases then random ops against an arithmetic reference model.
module tb_alu_seq;
    localparam int W     = 8;
    localparam int PCW   = 8;
    localparam longint unsigned MOD  = 64'd1 << W;
    localparam longint unsigned PMOD = 64'd1 << PCW;
    localparam longint unsigned SHN  = 64'd1 << $clog2(W);

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         illegal;
        int           busy;
        int           due;
        int           stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    alu_seq_if #(.WIDTH(W), .PC_WIDTH(PCW)) bus ();
    alu_seq #(.WIDTH(W), .PC_WIDTH(PCW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a8, input logic [W-1:0] b8,
                                   input logic [PCW-1:0] pc8);
        exp_t e;
        longint unsigned a = a8, b = b8, pc = pc8, full = 0;
        int n = int'(b % SHN);
        e.busy = 0; e.carry = 1'b0; e.illegal = 1'b0; e.due = 0; e.stall = 0;
        case (c)
            3'd0: begin full = a + b; e.carry = (full >= MOD); end
            3'd1: full = ~(a & b);
            3'd2: full = (a != 0) ? (pc + 1) % PMOD : b;
            3'd3: full = (a < b) ? 1 : 0;
            3'd4: begin full = a - b; e.carry = (a < b); end
            3'd5: begin
                full = a << n; e.busy = n;
                if (n != 0) e.carry = ((full / MOD) % 2) == 1;
            end
            3'd6: begin
                full = a >> n; e.busy = n;
                if (n != 0) e.carry = ((a >> (n - 1)) % 2) == 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                full = a * b; e.busy = W; e.carry = (full / MOD) != 0;
`else
                full = 0; e.illegal = 1'b1;
`endif
            end
        endcase
        e.res  = W'(full % MOD);
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Driver: present a request at a negedge, hold until accepted, then scramble the inputs.
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [PCW-1:0] pc, input int stall);
        exp_t e;
        int   waited = 0;
        bus.control = c; bus.dataInACC = a; bus.dataIn = b; bus.pc = pc; bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e       = model(c, a, b, pc);
        e.due   = cycle + 1 + e.busy;
        e.stall = stall;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.control   = 3'($urandom);
        bus.dataInACC = W'($urandom);
        bus.dataIn    = W'($urandom);
        bus.pc        = PCW'($urandom);
        @(negedge clk);
    endtask

    // Monitor: pops on each new result, then re-checks every held cycle until consumed.
    exp_t cur;
    bit   holding   = 1'b0;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
            bus.out_ready = 1'b0;
        end else if (bus.out_valid) begin
            if (!holding) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid: got=1 expected=0 (cycle %0d)", cycle);
                    bus.out_ready = 1'b1;
                end else begin
                    cur       = q.pop_front();
                    holding   = 1'b1;
                    stall_cnt = cur.stall;
                    check("latency", 64'(cycle), 64'(cur.due));
                end
            end
            if (holding) begin
                check("dataOut", 64'(bus.dataOut), 64'(cur.res));
                check("carry", 64'(bus.carry), 64'(cur.carry));
                check("zero", 64'(bus.zero), 64'(cur.zero));
                check("illegal", 64'(bus.illegal), 64'(cur.illegal));
                check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (stall_cnt > 0) begin
                    bus.out_ready = 1'b0;
                    stall_cnt--;
                end else begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                if (bus.out_ready) holding = 1'b0;
            end
        end else begin
            bus.out_ready = 1'($urandom);
        end
    end

    task automatic drain();
        for (int i = 0; i < 500 && (q.size() != 0 || holding || bus.out_valid); i++) @(negedge clk);
        check("drain_queue", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.control = '0; bus.dataInACC = '0; bus.dataIn = '0; bus.pc = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dataOut", 64'(bus.dataOut), 64'd0);
        check("rst_carry", 64'(bus.carry), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 8'hF0, 8'h20, 8'h00, 0);
        issue(3'b010, 8'h03, 8'h00, 8'hFF, 0);
        issue(3'b010, 8'h00, 8'h42, 8'hFF, 0);
        issue(3'b011, 8'h05, 8'h09, 8'h00, 0);
        issue(3'b001, 8'hF0, 8'h3C, 8'h00, 0);
        issue(3'b101, 8'h81, 8'h03, 8'h00, 0);
        issue(3'b110, 8'h81, 8'h00, 8'h00, 0);
        issue(3'b110, 8'h81, 8'h01, 8'h00, 0);
        issue(3'b100, 8'h02, 8'h05, 8'h00, 4);
        issue(3'b111, 8'h10, 8'h11, 8'h00, 0);
        issue(3'b000, 8'hFF, 8'h01, 8'h00, 0);
        drain();

        // Reset in the middle of a long multi-cycle op: the result must never appear.
`ifdef ALU_MUL_EN
        issue(3'b111, 8'h33, 8'h44, 8'h00, 0);
`else
        issue(3'b101, 8'h81, 8'h07, 8'h00, 0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_dataOut", 64'(bus.dataOut), 64'd0);
        check("midrst_carry", 64'(bus.carry), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_result", 64'(bus.out_valid), 64'd0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            issue(3'($urandom), a, W'($urandom), PCW'($urandom), ($urandom_range(0, 9) == 0) ? 3 : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
